// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter
//   Shares one byte-level UART transmitter among N_REQ packet sources.
//   The arbiter searches round-robin from a rotating pointer, holds the grant for
//   a whole packet, hands the bytes to the transmitter one at a time, and waits
//   for each byte's done pulse before it fetches the next one. A granted source
//   that leaves valid low mid-packet for HOLD_MAX cycles loses the grant.
//
// Ports
//   clk_ref      system clock
//   rst          synchronous active-high reset
//   i_req_valid  per-requester byte valid
//   i_req_data   byte of requester k in bits [8k+7:8k]
//   i_req_last   last byte of the packet, qualified by valid
//   o_req_ready  byte accept (only the owner, only while fetching)
//   o_grant      one-hot current owner, 0 when idle
//   o_tx_start   one-cycle load pulse to the transmitter
//   o_tx_data    byte to transmit, held from start through done
//   i_tx_busy    transmitter busy
//   i_tx_done    transmitter end-of-stop-bit pulse
//   o_active     high whenever the arbiter is not idle
//   o_abort      one-cycle pulse when a packet is dropped on hold timeout
module rs232_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int HOLD_MAX = 1000
) (
  input  logic               clk_ref,
  input  logic               rst,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_tx_start,
  output logic [7:0]         o_tx_data,
  input  logic               i_tx_busy,
  input  logic               i_tx_done,
  output logic               o_active,
  output logic               o_abort
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = PW + 1;
  localparam int HW = $clog2(HOLD_MAX);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [PW-1:0] IDX_LAST  = PW'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    gidx_q, gidx_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             last_q, last_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             abort_q, abort_d;

  logic             found;
  logic [PW-1:0]    sel_idx;
  logic [SW-1:0]    wrap_sum;
  logic [PW-1:0]    cand;
  logic             xfer;
  logic [7:0]       sel_data;
  logic             sel_last;
  logic [PW-1:0]    ptr_after;

  // Only the owner sees ready, and only while a byte is being fetched.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign o_req_ready[gi] = (state_q == ST_FETCH) && grant_q[gi] && i_req_valid[gi];
    end
  endgenerate

  assign xfer      = |o_req_ready;
  assign sel_data  = i_req_data[{gidx_q, 3'b000} +: 8];
  assign sel_last  = i_req_last[gidx_q];
  assign ptr_after = (gidx_q == IDX_LAST) ? '0 : gidx_q + PW'(1);

  // Round-robin search: visit ptr, ptr+1, ... modulo N_REQ, first valid wins.
  // The sum is one bit wider than the index so non-power-of-two N_REQ wraps
  // correctly.
  always_comb begin
    found    = 1'b0;
    sel_idx  = '0;
    wrap_sum = '0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      wrap_sum = {1'b0, ptr_q} + SW'(i);
      if (wrap_sum >= SW'(N_REQ)) begin
        wrap_sum = wrap_sum - SW'(N_REQ);
      end
      cand = wrap_sum[PW-1:0];
      if (!found && i_req_valid[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    hold_d     = hold_q;
    abort_d    = 1'b0;
    o_tx_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          gidx_d           = sel_idx;
          hold_d           = '0;
          state_d          = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // A byte arriving on the final count cycle is still taken.
        if (xfer) begin
          tx_data_d = sel_data;
          last_d    = sel_last;
          hold_d    = '0;
          state_d   = ST_START;
        end else if (hold_q == HOLD_LAST) begin
          abort_d = 1'b1;
          ptr_d   = ptr_after;
          grant_d = '0;
          hold_d  = '0;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_START: begin
        if (!i_tx_busy) begin
          o_tx_start = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_tx_done) begin
          if (last_q) begin
            ptr_d   = ptr_after;
            grant_d = '0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: begin
        grant_d = '0;
        hold_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      gidx_q    <= '0;
      tx_data_q <= '0;
      last_q    <= 1'b0;
      hold_q    <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      tx_data_q <= tx_data_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      abort_q   <= abort_d;
    end
  end

  assign o_grant   = grant_q;
  assign o_tx_data = tx_data_q;
  assign o_active  = (state_q != ST_IDLE);
  assign o_abort   = abort_q;

endmodule
